// File: rtl/calibration_stimulus.sv
// calibration_stimulus: phase/frame-grabber stimulus source and trigger delay/width meter
// Optional feature macro: CALIB_STIM_WIDTH_MEAS_EN (enables trigger width measurement)
// Ports:
//   clock, reset        - system clock, async active-high reset
//   start_signal        - level start request, sampled only in IDLE
//   trigger_in          - returned trigger, synchronous to clock
//   phase_signal        - free-running phase reference square wave
//   fg_signal           - frame-grabber pulse, FG_LEN clocks per start
//   busy                - high whenever not IDLE
//   measure_valid       - one-cycle pulse when measure_delay/trigger_width update
//   measure_delay       - clocks from last phase rise to trigger rise (saturating)
//   trigger_width       - trigger high time in clocks (saturating, 0 without the macro)
//   timeout_error       - sticky until reset or next accepted start
module calibration_stimulus #(
    parameter int PHASE_PERIOD   = 200,
    parameter int PHASE_HIGH     = 100,
    parameter int FG_LEN         = 50,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_signal,
    input  logic        trigger_in,
    output logic        phase_signal,
    output logic        fg_signal,
    output logic        busy,
    output logic        measure_valid,
    output logic [15:0] measure_delay,
    output logic [15:0] trigger_width,
    output logic        timeout_error
);
    localparam int PW = (PHASE_PERIOD > 2) ? $clog2(PHASE_PERIOD) : 1;

    typedef enum logic [2:0] {IDLE, FG_PULSE, WAIT_TRIGGER, MEASURE_WIDTH, REPORT} state_t;

    state_t        state;
    logic [PW-1:0] ph_cnt;
    logic [15:0]   phase_age;
    logic [31:0]   cnt;
    logic          trig_prev;
    logic          phase_next;
    logic          rise;

    assign phase_next = ph_cnt < PW'(PHASE_HIGH);
    assign rise       = trigger_in && !trig_prev;
    assign busy       = state != IDLE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ph_cnt        <= '0;
            phase_signal  <= 1'b0;
            phase_age     <= 16'hFFFF;
            trig_prev     <= 1'b0;
            cnt           <= '0;
            fg_signal     <= 1'b0;
            measure_valid <= 1'b0;
            measure_delay <= '0;
            trigger_width <= '0;
            timeout_error <= 1'b0;
        end else begin
            ph_cnt        <= (ph_cnt == PW'(PHASE_PERIOD - 1)) ? '0 : ph_cnt + 1'b1;
            phase_signal  <= phase_next;
            // age restarts so it reads 0 during the first high cycle of the phase wave
            phase_age     <= (phase_next && !phase_signal) ? '0 :
                             (phase_age == 16'hFFFF) ? phase_age : phase_age + 1'b1;
            trig_prev     <= trigger_in;
            measure_valid <= 1'b0;
            case (state)
                IDLE: if (start_signal) begin
                    state         <= FG_PULSE;
                    cnt           <= '0;
                    timeout_error <= 1'b0;
                    fg_signal     <= 1'b1;
                end
                FG_PULSE: begin
                    // cnt keeps running from pulse start so the trigger timeout includes the pulse
                    cnt <= cnt + 1'b1;
                    if (cnt == 32'(FG_LEN - 1)) begin
                        fg_signal <= 1'b0;
                        state     <= WAIT_TRIGGER;
                    end
                end
                WAIT_TRIGGER: if (rise) begin
                    measure_delay <= phase_age;
`ifdef CALIB_STIM_WIDTH_MEAS_EN
                    cnt           <= 32'd1;
                    state         <= MEASURE_WIDTH;
`else
                    // without width measurement the result is ready right after the rise
                    measure_valid <= 1'b1;
                    state         <= REPORT;
`endif
                end else if (cnt >= 32'(TIMEOUT_CYCLES)) begin
                    timeout_error <= 1'b1;
                    state         <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
`ifdef CALIB_STIM_WIDTH_MEAS_EN
                MEASURE_WIDTH: if (!trigger_in) begin
                    trigger_width <= (|cnt[31:16]) ? 16'hFFFF : cnt[15:0];
                    state         <= REPORT;
                end else if (cnt >= 32'(TIMEOUT_CYCLES)) begin
                    timeout_error <= 1'b1;
                    state         <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
`endif
                REPORT: begin
`ifdef CALIB_STIM_WIDTH_MEAS_EN
                    measure_valid <= 1'b1;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_calibration_stimulus.sv
// tb_calibration_stimulus: directed scoreboard bench for calibration_stimulus
module tb_calibration_stimulus;
    localparam int PERIOD = 200;
    localparam int HIGH   = 100;
    localparam int FG     = 50;
    localparam int TMO    = 1000;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_signal;
    logic        trigger_in;
    logic        phase_signal;
    logic        fg_signal;
    logic        busy;
    logic        measure_valid;
    logic [15:0] measure_delay;
    logic [15:0] trigger_width;
    logic        timeout_error;

    typedef struct {int d; int w; int c;} exp_t;
    exp_t q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    calibration_stimulus #(
        .PHASE_PERIOD(PERIOD), .PHASE_HIGH(HIGH), .FG_LEN(FG), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset), .start_signal(start_signal), .trigger_in(trigger_in),
        .phase_signal(phase_signal), .fg_signal(fg_signal), .busy(busy),
        .measure_valid(measure_valid), .measure_delay(measure_delay),
        .trigger_width(trigger_width), .timeout_error(timeout_error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && measure_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got pulse, expected none (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check("measure_delay", 32'(measure_delay), e.d);
                check("trigger_width", 32'(trigger_width), e.w);
                check("valid_cycle", cyc, e.c);
            end
        end
    end

    task automatic check_reset_outputs(string tag);
        check({tag, "_phase"}, 32'(phase_signal), 0);
        check({tag, "_fg"}, 32'(fg_signal), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_valid"}, 32'(measure_valid), 0);
        check({tag, "_delay"}, 32'(measure_delay), 0);
        check({tag, "_width"}, 32'(trigger_width), 0);
        check({tag, "_timeout"}, 32'(timeout_error), 0);
    endtask

    task automatic start_fg(bit glitch);
        int n = 0;
        start_signal = 1'b1;
        @(negedge clock);
        start_signal = 1'b0;
        check("busy_on_start", 32'(busy), 1);
        while (fg_signal && n < FG + 10) begin
            n++;
            if (glitch && n == 5) trigger_in = 1'b1;
            if (glitch && n == 15) trigger_in = 1'b0;
            @(negedge clock);
        end
        check("fg_len", n, FG);
        check("timeout_cleared", 32'(timeout_error), 0);
    endtask

    task automatic wait_phase_rise();
        bit   got = 1'b0;
        logic p;
        for (int i = 0; i < PERIOD + 5 && !got; i++) begin
            p = phase_signal;
            @(negedge clock);
            got = phase_signal && !p;
        end
        check("phase_rise_seen", 32'(got), 1);
    endtask

    task automatic measure(int d, int w);
        wait_phase_rise();
        repeat (d) @(negedge clock);
        trigger_in = 1'b1;
`ifndef CALIB_STIM_WIDTH_MEAS_EN
        q.push_back('{d, 0, cyc + 1});
`endif
        repeat (w) @(negedge clock);
        trigger_in = 1'b0;
`ifdef CALIB_STIM_WIDTH_MEAS_EN
        q.push_back('{d, w, cyc + 2});
`endif
        repeat (4) @(negedge clock);
        check("queue_drained", q.size(), 0);
        check("busy_after_report", 32'(busy), 0);
        check("no_timeout", 32'(timeout_error), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s;
        int n;
        reset = 1'b1;
        start_signal = 1'b0;
        trigger_in = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        for (int k = 0; k <= 401; k++) begin
            check("phase_wave", 32'(phase_signal), 32'(k >= 1 && (k - 1) % PERIOD < HIGH));
            if (k % 100 == 0) begin
                check("idle_fg", 32'(fg_signal), 0);
                check("idle_busy", 32'(busy), 0);
            end
            @(negedge clock);
        end

        start_fg(1'b0);
        measure(140, 100);

        start_fg(1'b0);
        measure(0, 1);

        s = cyc;
        start_fg(1'b0);
        for (n = 0; n < 2000 && busy; n++) @(negedge clock);
        check("wait_timeout_dur", 32'(cyc - s >= TMO + 1 && cyc - s <= TMO + 3), 1);
        check("wait_timeout_flag", 32'(timeout_error), 1);
        check("wait_timeout_busy", 32'(busy), 0);

        start_fg(1'b1);
        measure(30, 20);

`ifdef CALIB_STIM_WIDTH_MEAS_EN
        start_fg(1'b0);
        wait_phase_rise();
        trigger_in = 1'b1;
        for (n = 0; n < 2000 && busy; n++) @(negedge clock);
        check("width_timeout_flag", 32'(timeout_error), 1);
        check("width_timeout_busy", 32'(busy), 0);
        check("width_hold", 32'(trigger_width), 20);
        trigger_in = 1'b0;
        @(negedge clock);
`endif

        start_fg(1'b0);
        wait_phase_rise();
        repeat (50) @(negedge clock);
`ifdef CALIB_STIM_WIDTH_MEAS_EN
        trigger_in = 1'b1;
        repeat (10) @(negedge clock);
`endif
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset");
        trigger_in = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check("restart_phase_low", 32'(phase_signal), 0);
        @(negedge clock);
        check("restart_phase_high", 32'(phase_signal), 1);
        start_fg(1'b0);
        measure(60, 25);

        repeat (5) @(negedge clock);
        check("queue_empty_end", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/calibration_stimulus.md
# calibration_stimulus

Synthetic stimulus source and response meter for the calibration trigger path. It drives a free-running phase reference square wave and, on command, a frame-grabber pulse. It then waits for the trigger returned by the calibration FSM and reports two values: the delay from the most recent phase rising edge to the trigger rising edge, and the trigger width. It sits on the bench and self-test side of the synchronization block, in the same clock domain as the calibration FSM.

## Interface
- PHASE_PERIOD, 200 — phase wave period in clocks (≥2)
- PHASE_HIGH, 100 — phase high time in clocks (1..PHASE_PERIOD-1)
- FG_LEN, 50 — frame-grabber pulse length in clocks (≥1)
- TIMEOUT_CYCLES, 1_000_000 — max clocks from FG pulse start to trigger rise, and max trigger high time
- clock in 1 — system clock
- reset in 1 — asynchronous, active-high; clears all state
- start_signal in 1 — level; sampled in IDLE only
- trigger_in in 1 — trigger returned by the DUT path, synchronous to clock
- phase_signal out 1 — registered phase reference
- fg_signal out 1 — registered frame-grabber pulse
- busy out 1 — high in any state except IDLE
- measure_valid out 1 — one-cycle pulse when results update
- measure_delay out 16 — clocks from phase rise to trigger rise, saturating at 16'hFFFF
- trigger_width out 16 — trigger high time in clocks, saturating
- timeout_error out 1 — sticky; cleared by reset or by the next accepted start

## Operation
- Reset values: phase_signal=0, fg_signal=0, busy=0, measure_valid=0, measure_delay=0, trigger_width=0, timeout_error=0, ph_cnt=0, phase_age=16'hFFFF, trig_prev=0, state=IDLE.
- Phase generator:
  - ph_cnt counts 0..PHASE_PERIOD-1 and wraps; it runs in every state.
  - phase_signal <= (ph_cnt < PHASE_HIGH).
- Phase age:
  - phase_age <= 0 on the clock edge where phase_signal goes 0→1.
  - Otherwise phase_age increments, saturating at 16'hFFFF.
  - Result: phase_age reads 0 during the first high cycle.
- Edge detect: trig_prev <= trigger_in every cycle. A rise is trigger_in=1 && trig_prev=0.
- States:
  - IDLE: if start_signal, go to FG_PULSE; clear cnt and timeout_error; set fg_signal=1.
  - FG_PULSE: after FG_LEN cycles of fg_signal=1, drive fg_signal=0 and go to WAIT_TRIGGER. cnt keeps counting from FG pulse start.
  - WAIT_TRIGGER:
    - On a rise: measure_delay <= phase_age (value in the cycle trigger_in is first high); cnt <= 1; go to MEASURE_WIDTH.
    - Else if cnt reaches TIMEOUT_CYCLES: timeout_error=1; go to IDLE with no measure_valid.
  - MEASURE_WIDTH: while trigger_in=1, increment cnt.
    - On trigger_in=0: trigger_width <= cnt (saturated to 16 bits); go to REPORT.
    - If cnt reaches TIMEOUT_CYCLES: timeout_error=1; go to IDLE.
  - REPORT: measure_valid=1 for one cycle; go to IDLE.
- A trigger rise during FG_PULSE is ignored for measurement; only rises in WAIT_TRIGGER count.
- start_signal held high re-arms immediately on return to IDLE.
- start_signal has no effect outside IDLE.
- The cnt register is 32 bits.
- Unknown or illegal state encodings go to IDLE.

## Timing
- fg_signal rises 1 clock after start_signal is sampled high in IDLE and stays high exactly FG_LEN clocks.
- First phase_signal rise occurs 1 clock after reset release. After that the rise period is exactly PHASE_PERIOD clocks.
- Delay convention: trigger rising in the same cycle as the phase rise gives measure_delay=0; trigger rising k cycles later gives k.
- A trigger high for N clocks gives trigger_width=N.
- measure_valid asserts 2 clocks after the cycle trigger_in is first sampled low.
- measure_delay and trigger_width hold their values until the next update.
- Reset asserted mid-operation clears all outputs asynchronously. The phase generator restarts from ph_cnt=0.

## Configuration
- CALIB_STIM_WIDTH_MEAS_EN defined: MEASURE_WIDTH state present, behaving as described above.
- Undefined:
  - WAIT_TRIGGER goes directly to REPORT on a rise.
  - trigger_width is held at 0.
  - The width timeout does not exist.
  - measure_valid asserts 1 clock after the rise cycle.

## Test plan
- Reset release, no start → phase_signal rises at clocks 1, 201, 401, each high 100 clocks; fg_signal=0; busy=0.
- Start pulse; loopback model raises trigger 140 clocks after a phase rise (following FG), held 100 clocks → measure_delay=140, trigger_width=100, one measure_valid pulse, timeout_error=0.
- Start with trigger_in tied 0 → timeout_error=1 after TIMEOUT_CYCLES (parameter overridden to 1000); busy drops; no measure_valid.
- Trigger rises during FG_PULSE and falls before WAIT_TRIGGER, then rises again 30 clocks after a phase rise → measure_delay=30.
- Reset asserted mid-MEASURE_WIDTH → all outputs are reset values immediately (asynchronously); the next start measures normally.
- Macro undefined, same stimulus as scenario 2 → measure_delay=140, trigger_width=0, measure_valid 1 clock after the rise.
